// File: rtl/core_pkg.sv
// Shared core definitions: fetch datapath widths and the {pc, instr}
// record that travels from fetch through the instruction queue to decode.
package core_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/queue_ctrl.sv
// Pointer and occupancy management for the instruction queue.
// Head/tail wrap naturally at DEPTH (power of two); occupancy is a separate
// counter so full and empty are distinguished without an extra pointer bit.
module queue_ctrl #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic             deq_ready,
    output logic             full,
    output logic             empty,
    output logic             wr_en,
    output logic [PTR_W-1:0] head_idx,
    output logic [PTR_W-1:0] tail_idx,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_enq;
    logic             do_deq;

    // Status comes from registered count only, so fetch back-pressure has
    // no combinational dependence on deq_ready (no same-cycle full bypass).
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    assign do_enq = enq_valid && !full;
    assign do_deq = deq_ready && !empty;

    // Storage write is suppressed when the enqueue is being discarded.
    assign wr_en = do_enq && !flush && !reset;

    assign head_idx = head_reg;
    assign tail_idx = tail_reg;
    assign count    = count_reg;

    // Next-state pointers/count; flush overrides any same-cycle transfer.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (do_enq) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (do_deq) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode/rename. Holds up to DEPTH
// {pc, instr} entries in program order; the head entry is presented to
// decode through a combinational read indexed by the registered head.
module instr_queue #(
    parameter int ADDR_WIDTH  = core_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH,
    parameter int DEPTH       = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    input  logic [ADDR_WIDTH-1:0]  enq_pc,
    input  logic [INSTR_WIDTH-1:0] enq_instr,
    output logic                   enq_ready,
    output logic                   deq_valid,
    output logic [ADDR_WIDTH-1:0]  deq_pc,
    output logic [INSTR_WIDTH-1:0] deq_instr,
    input  logic                   deq_ready,
    output logic [CNT_W-1:0]       count
);

    // Same layout as core_pkg::fetch_entry_t, but sized by this block's
    // parameters so non-default widths still work.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head_entry;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;

    queue_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .enq_valid(enq_valid),
        .deq_ready(deq_ready),
        .full     (full),
        .empty    (empty),
        .wr_en    (wr_en),
        .head_idx (head_idx),
        .tail_idx (tail_idx),
        .count    (count)
    );

    assign enq_ready = !full;
    assign deq_valid = !empty;

    // Storage write at tail; contents are not reset (don't-care when empty).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail_idx] <= '{pc: enq_pc, instr: enq_instr};
        end
    end

    // Head entry is always visible; decode qualifies it with deq_valid.
    assign head_entry = mem[head_idx];
    assign deq_pc     = head_entry.pc;
    assign deq_instr  = head_entry.instr;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a table of per-cycle vectors with
// hand-computed post-edge expectations, plus a wrap-around streaming run.
module tb_instr_queue;
    import core_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic [11:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_ready;
    logic        deq_valid;
    logic [11:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instr_queue dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .enq_valid(enq_valid),
        .enq_pc   (enq_pc),
        .enq_instr(enq_instr),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid),
        .deq_pc   (deq_pc),
        .deq_instr(deq_instr),
        .deq_ready(deq_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ev;
        logic [11:0] pc;
        logic        dr;
        logic [2:0]  exp_count;
        logic        exp_er;
        logic        exp_dv;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk_instr(input logic [11:0] pc);
        return {20'hC0DE5, pc};
    endfunction

    task automatic add(input logic rst, input logic fl, input logic ev,
                       input logic [11:0] pc, input logic dr,
                       input logic [2:0] c, input logic er, input logic dv,
                       input logic [11:0] hpc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.ev = ev; v.pc = pc; v.dr = dr;
        v.exp_count = c; v.exp_er = er; v.exp_dv = dv; v.exp_pc = hpc;
        vecs.push_back(v);
    endtask

    task automatic check_bit(input string name, input int idx,
                             input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step%0d: got %0b expected %0b", name, idx, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int idx,
                             input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step%0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic check_head(input int idx, input logic [11:0] hpc);
        fetch_entry_t e;
        e.pc    = hpc;
        e.instr = mk_instr(hpc);
        check_val("deq_pc", idx, 32'(deq_pc), 32'(e.pc));
        check_val("deq_instr", idx, deq_instr, e.instr);
    endtask

    task automatic drive(input logic rst, input logic fl, input logic ev,
                         input logic [11:0] pc, input logic dr);
        reset     = rst;
        flush     = fl;
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = mk_instr(pc);
        deq_ready = dr;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);

        //  rst fl ev  pc      dr   count er dv head_pc
        // reset state
        add(1, 0, 0, 12'h000, 0,   0, 1, 0, 12'h000);
        // fill with decode stalled
        add(0, 0, 1, 12'h000, 0,   1, 1, 1, 12'h000);
        add(0, 0, 1, 12'h004, 0,   2, 1, 1, 12'h000);
        add(0, 0, 1, 12'h008, 0,   3, 1, 1, 12'h000);
        add(0, 0, 1, 12'h00C, 0,   4, 0, 1, 12'h000);
        // fifth enqueue dropped while full
        add(0, 0, 1, 12'h010, 0,   4, 0, 1, 12'h000);
        // drain
        add(0, 0, 0, 12'h000, 1,   3, 1, 1, 12'h004);
        add(0, 0, 0, 12'h000, 1,   2, 1, 1, 12'h008);
        add(0, 0, 0, 12'h000, 1,   1, 1, 1, 12'h00C);
        add(0, 0, 0, 12'h000, 1,   0, 1, 0, 12'h000);
        // deq_ready on empty queue is ignored
        add(0, 0, 0, 12'h000, 1,   0, 1, 0, 12'h000);
        // refill, then dequeue while full: enqueue of 0x100 dropped
        add(0, 0, 1, 12'h040, 0,   1, 1, 1, 12'h040);
        add(0, 0, 1, 12'h044, 0,   2, 1, 1, 12'h040);
        add(0, 0, 1, 12'h048, 0,   3, 1, 1, 12'h040);
        add(0, 0, 1, 12'h04C, 0,   4, 0, 1, 12'h040);
        add(0, 0, 1, 12'h100, 1,   3, 1, 1, 12'h044);
        add(0, 0, 0, 12'h000, 0,   3, 1, 1, 12'h044);
        // flush with concurrent enqueue and dequeue
        add(0, 1, 1, 12'h200, 1,   0, 1, 0, 12'h000);
        add(0, 0, 1, 12'h300, 0,   1, 1, 1, 12'h300);
        add(0, 0, 0, 12'h000, 0,   1, 1, 1, 12'h300);
        // reset over flush and enqueue with two entries queued
        add(0, 0, 1, 12'h304, 0,   2, 1, 1, 12'h300);
        add(1, 1, 1, 12'h308, 0,   0, 1, 0, 12'h000);
        add(0, 0, 0, 12'h000, 0,   0, 1, 0, 12'h000);
        add(0, 0, 1, 12'h30C, 0,   1, 1, 1, 12'h30C);
        add(0, 0, 0, 12'h000, 1,   0, 1, 0, 12'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].dr);
            @(posedge clk);
            #1;
            $display("step%0d rst=%0b fl=%0b ev=%0b pc=0x%03h dr=%0b -> count=%0d er=%0b dv=%0b head=0x%03h",
                     i, vecs[i].rst, vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].dr,
                     count, enq_ready, deq_valid, deq_pc);
            check_val("count", i, 32'(count), 32'(vecs[i].exp_count));
            check_bit("enq_ready", i, enq_ready, vecs[i].exp_er);
            check_bit("deq_valid", i, deq_valid, vecs[i].exp_dv);
            if (vecs[i].exp_dv) check_head(i, vecs[i].exp_pc);
        end

        // Wrap-around streaming: preload 0x020, then enqueue and dequeue
        // together for 10 cycles; the head advances by 4 each cycle.
        drive(1'b0, 1'b0, 1'b1, 12'h020, 1'b0);
        @(posedge clk);
        #1;
        check_val("stream_preload_count", 100, 32'(count), 32'd1);
        for (int k = 0; k < 10; k++) begin
            logic [11:0] exp_head;
            logic [11:0] new_pc;
            exp_head = 12'h020 + 12'(4 * k);
            new_pc   = 12'h024 + 12'(4 * k);
            check_bit("stream_dv", 101 + k, deq_valid, 1'b1);
            check_head(101 + k, exp_head);
            drive(1'b0, 1'b0, 1'b1, new_pc, 1'b1);
            @(posedge clk);
            #1;
            $display("stream%0d enq=0x%03h deq=0x%03h -> count=%0d head=0x%03h",
                     k, new_pc, exp_head, count, deq_pc);
            check_val("stream_count", 101 + k, 32'(count), 32'd1);
        end
        check_head(111, 12'h048);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        @(posedge clk);
        #1;
        check_bit("stream_drain_dv", 112, deq_valid, 1'b0);
        check_val("stream_drain_count", 112, 32'(count), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
